// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and
// the data (LDR/STR) port, with a bounded-starvation priority for fetch.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stallF,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               if_valid_q, if_valid_d;
    logic               dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;
    logic               if_eff_s, dm_eff_s, grant_f_s, grant_d_s;

    // A port whose completion pulses this cycle must not be re-granted on a stale request.
    assign if_eff_s = if_req & ~if_valid_q;
    assign dm_eff_s = dm_req & ~dm_valid_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and grant decision
    always_comb begin
        state_d   = state_q;
        grant_f_s = 1'b0;
        grant_d_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_eff_s && dm_eff_s) begin
                    if (starve_cnt_q < CNT_W'(STARVE_LIMIT)) begin
                        grant_d_s = 1'b1;
                    end else begin
                        grant_f_s = 1'b1;
                    end
                end else if (if_eff_s) begin
                    grant_f_s = 1'b1;
                end else if (dm_eff_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_f_s = 1'b0;
                end
                if (grant_f_s) begin
                    state_d = ST_FETCH;
                end else if (grant_d_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_f_s) begin
                    mem_addr_d   = if_addr;
                    mem_we_d     = 1'b0;
                    starve_cnt_d = '0;
                end else if (grant_d_s) begin
                    mem_addr_d  = dm_addr;
                    mem_we_d    = dm_we;
                    mem_wdata_d = dm_wdata;
                    if (if_eff_s && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                end else begin
                    starve_cnt_d = starve_cnt_q;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end else begin
                    if_valid_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (mem_ready) begin
                    dm_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end else begin
                        dm_rdata_d = dm_rdata_q;
                    end
                end else begin
                    dm_valid_d = 1'b0;
                end
            end
            default: begin
                if_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_valid_q   <= if_valid_d;
            dm_valid_q   <= dm_valid_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign mem_req   = (state_q != ST_IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stallF    = if_req & ~if_valid_q;
    assign stallM    = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a cycle-level
// reference model built from the arbitration rules.
module tb_mem_port_arbiter;

    localparam int LIM = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_valid, dm_valid, stallF, stallM, mem_req, mem_we;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data) plus latched values.
    int          m_own;
    int          m_cnt;
    logic        m_we, m_ifv, m_dmv;
    logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .stallF(stallF),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stallM(stallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_cnt = 0; m_we = 1'b0; m_ifv = 1'b0; m_dmv = 1'b0;
        m_addr = '0; m_wdata = '0; m_ifr = '0; m_dmr = '0;
    endtask

    task automatic check_all();
        chk("mem_req",   {63'd0, mem_req},  {63'd0, m_own != 0});
        chk("mem_we",    {63'd0, mem_we},   {63'd0, m_we});
        chk("mem_addr",  {32'd0, mem_addr}, {32'd0, m_addr});
        chk("mem_wdata", {32'd0, mem_wdata},{32'd0, m_wdata});
        chk("if_valid",  {63'd0, if_valid}, {63'd0, m_ifv});
        chk("dm_valid",  {63'd0, dm_valid}, {63'd0, m_dmv});
        chk("if_rdata",  {32'd0, if_rdata}, {32'd0, m_ifr});
        chk("dm_rdata",  {32'd0, dm_rdata}, {32'd0, m_dmr});
        chk("stallF",    {63'd0, stallF},   {63'd0, if_req & ~m_ifv});
        chk("stallM",    {63'd0, stallM},   {63'd0, dm_req & ~m_dmv});
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int          own_n, cnt_n, pick;
        logic        we_n, ifv_n, dmv_n, fe, de;
        logic [31:0] addr_n, wdata_n, ifr_n, dmr_n;
        own_n = m_own; cnt_n = m_cnt; we_n = m_we; addr_n = m_addr;
        wdata_n = m_wdata; ifr_n = m_ifr; dmr_n = m_dmr;
        ifv_n = 1'b0; dmv_n = 1'b0;
        if (m_own == 0) begin
            fe = if_req && !m_ifv;
            de = dm_req && !m_dmv;
            if (fe && de) pick = (m_cnt < LIM) ? 2 : 1;
            else if (fe)  pick = 1;
            else if (de)  pick = 2;
            else          pick = 0;
            if (pick == 1) begin
                own_n = 1; addr_n = if_addr; we_n = 1'b0; cnt_n = 0;
            end else if (pick == 2) begin
                own_n = 2; addr_n = dm_addr; we_n = dm_we; wdata_n = dm_wdata;
                if (fe) cnt_n = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
            end
        end else if (mem_ready) begin
            if (m_own == 1) begin
                ifv_n = 1'b1; ifr_n = mem_rdata;
            end else begin
                dmv_n = 1'b1;
                if (!m_we) dmr_n = mem_rdata;
            end
            own_n = 0;
        end
        m_own = own_n; m_cnt = cnt_n; m_we = we_n; m_addr = addr_n;
        m_wdata = wdata_n; m_ifr = ifr_n; m_dmr = dmr_n; m_ifv = ifv_n; m_dmv = dmv_n;
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic step();
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        step();

        // Fetch-only read completing in the second busy cycle.
        if_req = 1'b1; if_addr = 32'h0000_0100;
        step();
        chk("t1_addr_c1", {32'd0, mem_addr}, 64'h100);
        step();
        chk("t1_req_c2", {63'd0, mem_req}, 64'd1);
        mem_ready = 1'b1; mem_rdata = 32'hE3A0_1005;
        step();
        mem_ready = 1'b0;
        chk("t1_ifv_c3", {63'd0, if_valid}, 64'd1);
        chk("t1_rdata", {32'd0, if_rdata}, 64'hE3A0_1005);
        step();
        if_req = 1'b0;
        step();

        // Simultaneous requests with mem_ready tied high: data first, then fetch.
        if_req = 1'b1; if_addr = 32'h0000_0104;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        chk("t2_data_first", {32'd0, mem_addr}, 64'h200);
        step();
        chk("t2_dmv", {63'd0, dm_valid}, 64'd1);
        dm_req = 1'b0; mem_rdata = 32'hCAFE_0001;
        step();
        chk("t2_fetch_next", {32'd0, mem_addr}, 64'h104);
        step();
        chk("t2_ifv", {63'd0, if_valid}, 64'd1);
        if_req = 1'b0; mem_ready = 1'b0;
        step();

        // Store with delayed ready: dm_rdata must not change.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h5555_AAAA;
        step();
        chk("t4_we", {63'd0, mem_we}, 64'd1);
        chk("t4_wdata", {32'd0, mem_wdata}, 64'hDEAD_BEEF);
        step(); step();
        mem_ready = 1'b1;
        step();
        chk("t4_dmv", {63'd0, dm_valid}, 64'd1);
        chk("t4_rdata_kept", {32'd0, dm_rdata}, 64'h1234_5678);
        dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
        step();

        // Reset while a fetch is outstanding.
        if_req = 1'b1; if_addr = 32'h300;
        step();
        chk("t5_busy", {63'd0, mem_req}, 64'd1);
        do_reset();
        if_req = 1'b0;
        step(); step();

        // mem_ready in IDLE with no requests does nothing.
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step(); step(); step();
        mem_ready = 1'b0;

        // Randomized traffic, including dropped requests and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if_req    = ($urandom_range(0, 99) < 60);
            dm_req    = ($urandom_range(0, 99) < 60);
            dm_we     = $urandom_range(0, 1) == 1;
            if_addr   = $urandom;
            dm_addr   = $urandom;
            dm_wdata  = $urandom;
            mem_rdata = $urandom;
            mem_ready = ($urandom_range(0, 99) < 55);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        idle_inputs();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
